operand_debounce: RTL and testbench

Input-conditioning stage ahead of the 4-bit adder datapath. It synchronizes and debounces the eight operand slide switches and two push buttons. On each Btn0 press it captures a stable operand pair (OpX, OpY), and each Btn1 press toggles the carry-in. The adder and display stages therefore see only clean, press-qualified values, plus a one-cycle Load strobe per new operand set.

---
 rtl/operand_debounce_if.sv | 27 ++
 rtl/operand_debounce.sv | 94 +++++++++
 tb/tb_operand_debounce.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_debounce_if
//  Purpose  : Raw switch/button inputs and conditioned operand outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface operand_debounce_if;
   logic       Sw0, Sw1, Sw2, Sw3, Sw4, Sw5, Sw6, Sw7;
   logic       Btn0;
   logic       Btn1;
   logic [3:0] OpX;
   logic [3:0] OpY;
   logic       Cin;
   logic       Load;
   logic [7:0] SwDeb;

   modport master (
      output Sw0, Sw1, Sw2, Sw3, Sw4, Sw5, Sw6, Sw7, Btn0, Btn1,
      input  OpX, OpY, Cin, Load, SwDeb
   );

   modport slave (
      input  Sw0, Sw1, Sw2, Sw3, Sw4, Sw5, Sw6, Sw7, Btn0, Btn1,
      output OpX, OpY, Cin, Load, SwDeb
   );
endinterface
`default_nettype wire

// File: rtl/operand_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : operand_debounce
//  Purpose  : Synchronize/debounce 8 switches + 2 buttons; capture operands.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_debounce #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic              Clk,
   input  logic              Rst_n,
   operand_debounce_if.slave bus
);
   localparam int               c_nch      = 10;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [c_nch-1:0] w_raw;
   logic [c_nch-1:0] w_deb;
   logic [1:0]       r_btn_q;
   logic             w_load_press;
   logic             w_cin_press;
   logic [3:0]       r_opx;
   logic [3:0]       r_opy;
   logic             r_cin;
   logic             r_load;

   // Channels 0..7 are Sw0..Sw7, channel 8 is Btn0, channel 9 is Btn1.
   assign w_raw = {bus.Btn1, bus.Btn0, bus.Sw7, bus.Sw6, bus.Sw5,
                   bus.Sw4,  bus.Sw3,  bus.Sw2, bus.Sw1, bus.Sw0};

   generate
      for (genvar gi = 0; gi < c_nch; gi++) begin : g_chan
         logic             r_s1;
         logic             r_s2;
         logic             r_deb;
         logic [CNT_W-1:0] r_cnt;

         // Any sample agreeing with the current level restarts the count.
         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               r_s1  <= 1'b0;
               r_s2  <= 1'b0;
               r_deb <= 1'b0;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_cnt_last) begin
                  r_deb <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
         end

         assign w_deb[gi] = r_deb;
      end
   endgenerate

   assign w_load_press = w_deb[8] & ~r_btn_q[0];
   assign w_cin_press  = w_deb[9] & ~r_btn_q[1];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_btn_q <= 2'b00;
         r_opx   <= 4'h0;
         r_opy   <= 4'h0;
         r_cin   <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_btn_q <= w_deb[9:8];
         r_load  <= w_load_press;
         if (w_load_press) begin
            r_opx <= w_deb[3:0];
            r_opy <= w_deb[7:4];
         end
         if (w_cin_press) begin
            r_cin <= ~r_cin;
         end
      end
   end

   assign bus.OpX   = r_opx;
   assign bus.OpY   = r_opy;
   assign bus.Cin   = r_cin;
   assign bus.Load  = r_load;
   assign bus.SwDeb = w_deb[7:0];
endmodule
`default_nettype wire

// File: tb/tb_operand_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_debounce
//  Purpose  : Self-checking bench for operand_debounce against a history model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_debounce;
   localparam int DEB = 4;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b1;

   operand_debounce_if bus();

   operand_debounce #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // Model: a level flips once the last DEB synchronized samples all disagree
   // with it; synchronized sample at edge n is the raw value seen at edge n-2.
   logic [9:0] raw;
   logic [7:0] m_hist [10];
   logic [9:0] m_deb;
   logic [9:0] m_debq;
   logic [3:0] m_opx;
   logic [3:0] m_opy;
   logic       m_cin;
   logic       m_load;
   logic       m_p0;
   logic       m_p1;

   assign raw  = {bus.Btn1, bus.Btn0, bus.Sw7, bus.Sw6, bus.Sw5,
                  bus.Sw4,  bus.Sw3,  bus.Sw2, bus.Sw1, bus.Sw0};
   assign m_p0 = m_deb[8] & ~m_debq[8];
   assign m_p1 = m_deb[9] & ~m_debq[9];

   function automatic logic flips(input logic [7:0] h, input logic d);
      for (int j = 1; j <= DEB; j++) begin
         if (h[j] == d) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < 10; i++) m_hist[i] <= 8'h00;
         m_deb  <= '0;
         m_debq <= '0;
         m_opx  <= 4'h0;
         m_opy  <= 4'h0;
         m_cin  <= 1'b0;
         m_load <= 1'b0;
      end else begin
         for (int i = 0; i < 10; i++) begin
            m_hist[i] <= {m_hist[i][6:0], raw[i]};
            if (flips(m_hist[i], m_deb[i])) m_deb[i] <= ~m_deb[i];
         end
         m_debq <= m_deb;
         m_load <= m_p0;
         if (m_p0) begin
            m_opx <= m_deb[3:0];
            m_opy <= m_deb[7:4];
         end
         if (m_p1) m_cin <= ~m_cin;
      end
   end

   int         checks = 0;
   int         errors = 0;
   int         n_load = 0;
   int         last_load_cyc = -1;
   int         rise3_cyc = -1;
   logic [3:0] last_opx = 4'h0;
   logic [3:0] last_opy = 4'h0;
   logic       last_cin = 1'b0;
   logic       prev3 = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare every output against the model, then return just
   // after the falling edge so the caller can drive new inputs.
   task automatic tick();
      @(negedge Clk);
      check("outputs", 32'({bus.SwDeb, bus.OpX, bus.OpY, bus.Cin, bus.Load}),
                       32'({m_deb[7:0], m_opx, m_opy, m_cin, m_load}));
      if (bus.Load) begin
         n_load++;
         last_load_cyc = cyc;
         last_opx = bus.OpX;
         last_opy = bus.OpY;
         last_cin = bus.Cin;
      end
      if (bus.SwDeb[3] && !prev3) rise3_cyc = cyc;
      prev3 = bus.SwDeb[3];
      #2;
   endtask

   task automatic set_in(input logic [7:0] sw, input logic b0, input logic b1);
      {bus.Sw7, bus.Sw6, bus.Sw5, bus.Sw4, bus.Sw3, bus.Sw2, bus.Sw1, bus.Sw0} = sw;
      bus.Btn0 = b0;
      bus.Btn1 = b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          nl;
      int          c0;
      logic        cin_seq [3];
      logic [31:0] v;

      set_in(8'h00, 1'b0, 1'b0);
      #3 Rst_n = 1'b0;
      repeat (3) tick();
      check("reset_outs", 32'({bus.SwDeb, bus.OpX, bus.OpY, bus.Cin, bus.Load}), 32'h0);
      Rst_n = 1'b1;

      // Latency: button captured at edge c0+1, Load seen after edge c0+DEB+3
      set_in(8'hA5, 1'b0, 1'b0);
      repeat (10) tick();
      check("swdeb_a5", 32'(bus.SwDeb), 32'hA5);
      nl = n_load;
      c0 = cyc;
      set_in(8'hA5, 1'b1, 1'b0);
      repeat (12) tick();
      check("lat_load_cyc", 32'(last_load_cyc), 32'(c0 + DEB + 3));
      check("lat_load_cnt", 32'(n_load - nl), 32'd1);
      check("lat_opx", 32'(last_opx), 32'h5);
      check("lat_opy", 32'(last_opy), 32'hA);
      set_in(8'hA5, 1'b0, 1'b0);
      repeat (10) tick();

      // Glitch rejection: 3-cycle pulses never load, a 4-cycle pulse does
      nl = n_load;
      repeat (5) begin
         set_in(8'h00, 1'b1, 1'b0);
         repeat (3) tick();
         set_in(8'h00, 1'b0, 1'b0);
         repeat (3) tick();
      end
      check("glitch_no_load", 32'(n_load - nl), 32'd0);
      check("glitch_opx", 32'(bus.OpX), 32'h5);
      set_in(8'h00, 1'b1, 1'b0);
      repeat (4) tick();
      set_in(8'h00, 1'b0, 1'b0);
      repeat (12) tick();
      check("glitch4_load", 32'(n_load - nl), 32'd1);
      check("glitch4_opx", 32'(last_opx), 32'h0);

      // Bounce on Sw3, then a steady high
      set_in(8'h08, 1'b0, 1'b0);
      repeat (2) tick();
      set_in(8'h00, 1'b0, 1'b0);
      repeat (2) tick();
      set_in(8'h08, 1'b0, 1'b0);
      c0 = cyc;
      repeat (12) tick();
      check("bounce_rise", 32'(rise3_cyc), 32'(c0 + DEB + 2));

      // Carry-in toggles, no loads
      check("cin_start", 32'(bus.Cin), 32'd0);
      nl = n_load;
      for (int p = 0; p < 3; p++) begin
         set_in(8'h08, 1'b0, 1'b1);
         repeat (20) tick();
         cin_seq[p] = bus.Cin;
         set_in(8'h08, 1'b0, 1'b0);
         repeat (20) tick();
      end
      check("cin_p1", 32'(cin_seq[0]), 32'd1);
      check("cin_p2", 32'(cin_seq[1]), 32'd0);
      check("cin_p3", 32'(cin_seq[2]), 32'd1);
      check("cin_no_load", 32'(n_load - nl), 32'd0);

      // Simultaneous presses: Load cycle already shows the toggled Cin
      set_in(8'h3C, 1'b0, 1'b0);
      repeat (10) tick();
      nl = n_load;
      set_in(8'h3C, 1'b1, 1'b1);
      repeat (12) tick();
      check("sim_load_cnt", 32'(n_load - nl), 32'd1);
      check("sim_opx", 32'(last_opx), 32'hC);
      check("sim_opy", 32'(last_opy), 32'h3);
      check("sim_cin", 32'(last_cin), 32'd0);
      set_in(8'h3C, 1'b0, 1'b0);
      repeat (12) tick();

      // Random bouncing inputs against the model
      repeat (150) begin
         v = $urandom;
         set_in(v[7:0], v[8], v[9]);
         repeat ($urandom_range(1, 9)) tick();
      end
      set_in(8'h00, 1'b0, 1'b0);
      repeat (12) tick();

      // Asynchronous reset mid-cycle with everything held high
      set_in(8'hFF, 1'b1, 1'b1);
      repeat (12) tick();
      check("pre_reset_swdeb", 32'(bus.SwDeb), 32'hFF);
      #4 Rst_n = 1'b0;
      #1;
      check("async_reset", 32'({bus.SwDeb, bus.OpX, bus.OpY, bus.Cin, bus.Load}), 32'h0);
      repeat (2) tick();
      Rst_n = 1'b1;
      nl = n_load;
      repeat (20) tick();
      check("held_load_cnt", 32'(n_load - nl), 32'd1);
      check("held_opx", 32'(last_opx), 32'hF);
      check("held_opy", 32'(last_opy), 32'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
